// File: rtl/pacman_collision_ctrl.sv
// Pac-Man catch detector and death / respawn / game-over sequencer.
// Define PACMAN_SWAP_DETECT_EN to also catch player/ghost pass-throughs on the same edge.
module pacman_collision_ctrl #(
   parameter int NUM_GHOSTS     = 4,
   parameter int X_W            = 10,
   parameter int Y_W            = 9,
   parameter int INIT_LIVES     = 3,
   parameter int DEATH_CYCLES   = 25_000_000,
   parameter int RESPAWN_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [X_W-1:0]            player_x,
   input  logic [Y_W-1:0]            player_y,
   input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
   input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
   input  logic                      start,
   output logic [1:0]                lives,
   output logic                      freeze,
   output logic                      ghost_reset_n,
   output logic                      player_reset_n,
   output logic                      death_pulse,
   output logic [NUM_GHOSTS-1:0]     hit_mask,
   output logic                      game_over
);

   localparam int MAX_CNT = (DEATH_CYCLES > RESPAWN_CYCLES) ? DEATH_CYCLES : RESPAWN_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [1:0] {PLAY, DYING, RESPAWN, GAME_OVER} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              lives_q, lives_d;
   logic                    freeze_q, freeze_d;
   logic                    grst_n_q, grst_n_d;
   logic                    prst_n_q, prst_n_d;
   logic                    pulse_q, pulse_d;
   logic [NUM_GHOSTS-1:0]   mask_q, mask_d;
   logic                    over_q, over_d;
   logic [NUM_GHOSTS-1:0]   hit;
   logic                    any_hit;

`ifdef PACMAN_SWAP_DETECT_EN
   logic                             prev_valid_q;
   logic [X_W-1:0]                   prev_px_q;
   logic [Y_W-1:0]                   prev_py_q;
   logic [NUM_GHOSTS-1:0][X_W-1:0]   prev_gx_q;
   logic [NUM_GHOSTS-1:0][Y_W-1:0]   prev_gy_q;

   // History is only trusted after one full PLAY cycle, so stale pre-death positions never match.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_valid_q <= 1'b0;
         prev_px_q    <= '0;
         prev_py_q    <= '0;
         prev_gx_q    <= '0;
         prev_gy_q    <= '0;
      end else if (state_q == PLAY) begin
         prev_valid_q <= ~any_hit;
         prev_px_q    <= player_x;
         prev_py_q    <= player_y;
         prev_gx_q    <= ghost_x;
         prev_gy_q    <= ghost_y;
      end else begin
         prev_valid_q <= 1'b0;
      end
   end
`endif

   for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_cmp
      logic direct;
      assign direct = (ghost_x[g*X_W +: X_W] == player_x) &&
                      (ghost_y[g*Y_W +: Y_W] == player_y);
`ifdef PACMAN_SWAP_DETECT_EN
      logic swap;
      assign swap = prev_valid_q &&
                    (ghost_x[g*X_W +: X_W] == prev_px_q) &&
                    (ghost_y[g*Y_W +: Y_W] == prev_py_q) &&
                    (player_x == prev_gx_q[g]) &&
                    (player_y == prev_gy_q[g]);
      assign hit[g] = direct | swap;
`else
      assign hit[g] = direct;
`endif
   end

   assign any_hit = |hit;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lives_d  = lives_q;
      freeze_d = freeze_q;
      grst_n_d = grst_n_q;
      prst_n_d = prst_n_q;
      pulse_d  = 1'b0;
      mask_d   = mask_q;
      over_d   = over_q;
      unique case (state_q)
         PLAY: begin
            if (any_hit) begin
               state_d  = DYING;
               lives_d  = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               pulse_d  = 1'b1;
               mask_d   = hit;
               freeze_d = 1'b1;
               cnt_d    = CNT_W'(DEATH_CYCLES - 1);
            end
         end
         DYING: begin
            if (cnt_q == '0) begin
               if (lives_q == 2'd0) begin
                  state_d = GAME_OVER;
                  over_d  = 1'b1;
               end else begin
                  state_d  = RESPAWN;
                  cnt_d    = CNT_W'(RESPAWN_CYCLES - 1);
                  grst_n_d = 1'b0;
                  prst_n_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESPAWN: begin
            if (cnt_q == '0) begin
               state_d  = PLAY;
               grst_n_d = 1'b1;
               prst_n_d = 1'b1;
               freeze_d = 1'b0;
               mask_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAME_OVER: begin
            if (start) begin
               state_d  = RESPAWN;
               lives_d  = 2'(INIT_LIVES);
               over_d   = 1'b0;
               cnt_d    = CNT_W'(RESPAWN_CYCLES - 1);
               grst_n_d = 1'b0;
               prst_n_d = 1'b0;
               freeze_d = 1'b1;
            end
         end
         default: state_d = PLAY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= PLAY;
         cnt_q    <= '0;
         lives_q  <= 2'(INIT_LIVES);
         freeze_q <= 1'b0;
         grst_n_q <= 1'b1;
         prst_n_q <= 1'b1;
         pulse_q  <= 1'b0;
         mask_q   <= '0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lives_q  <= lives_d;
         freeze_q <= freeze_d;
         grst_n_q <= grst_n_d;
         prst_n_q <= prst_n_d;
         pulse_q  <= pulse_d;
         mask_q   <= mask_d;
         over_q   <= over_d;
      end
   end

   assign lives          = lives_q;
   assign freeze         = freeze_q;
   assign ghost_reset_n  = grst_n_q;
   assign player_reset_n = prst_n_q;
   assign death_pulse    = pulse_q;
   assign hit_mask       = mask_q;
   assign game_over      = over_q;

endmodule

// File: tb/tb_pacman_collision_ctrl.sv
// Randomized + directed bench for pacman_collision_ctrl against a timeline-based game model.
module tb_pacman_collision_ctrl;
   localparam int NG = 4, XW = 10, YW = 9, IL = 3, DC = 8, RC = 2;
`ifdef PACMAN_SWAP_DETECT_EN
   localparam bit SWAP = 1'b1;
`else
   localparam bit SWAP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [XW-1:0]   player_x;
   logic [YW-1:0]   player_y;
   logic [NG*XW-1:0] ghost_x;
   logic [NG*YW-1:0] ghost_y;
   logic            start;
   logic [1:0]      lives;
   logic            freeze, ghost_reset_n, player_reset_n, death_pulse, game_over;
   logic [NG-1:0]   hit_mask;

   pacman_collision_ctrl #(.NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .INIT_LIVES(IL),
                           .DEATH_CYCLES(DC), .RESPAWN_CYCLES(RC)) dut (
      .clk(clk), .reset(reset), .player_x(player_x), .player_y(player_y),
      .ghost_x(ghost_x), .ghost_y(ghost_y), .start(start), .lives(lives),
      .freeze(freeze), .ghost_reset_n(ghost_reset_n), .player_reset_n(player_reset_n),
      .death_pulse(death_pulse), .hit_mask(hit_mask), .game_over(game_over));

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   // Stimulus as plain integers; the model reads the same values
   int px, py, gx[NG], gy[NG];
   bit st;
   // Model: age = cycles since the death sequence began (-1 when not sequencing);
   // ages [0,DC) are dying, [DC,DC+RC) respawn.
   int age, m_lives, ppx, ppy, pgx[NG], pgy[NG];
   bit over, pv, m_pulse;
   logic [NG-1:0] m_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      player_x = XW'(px);
      player_y = YW'(py);
      for (int g = 0; g < NG; g++) begin
         ghost_x[g*XW +: XW] = XW'(gx[g]);
         ghost_y[g*YW +: YW] = YW'(gy[g]);
      end
      start = st;
   endtask

   task automatic mdl_reset();
      age = -1; over = 0; m_lives = IL; m_mask = '0; m_pulse = 0; pv = 0;
   endtask

   task automatic mdl_step();
      logic [NG-1:0] h;
      m_pulse = 0;
      if (over) begin
         if (st) begin over = 0; m_lives = IL; age = DC; end
      end else if (age >= 0) begin
         age++;
         if (age == DC && m_lives == 0) begin over = 1; age = -1; end
         else if (age == DC + RC) begin age = -1; m_mask = '0; end
      end else begin
         h = '0;
         for (int g = 0; g < NG; g++) begin
            if (gx[g] == px && gy[g] == py) h[g] = 1'b1;
            if (SWAP && pv && gx[g] == ppx && gy[g] == ppy && px == pgx[g] && py == pgy[g])
               h[g] = 1'b1;
         end
         if (h != '0) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_mask = h; m_pulse = 1; age = 0; pv = 0;
         end else begin
            ppx = px; ppy = py;
            for (int g = 0; g < NG; g++) begin pgx[g] = gx[g]; pgy[g] = gy[g]; end
            pv = 1;
         end
      end
   endtask

   task automatic check_outs();
      bit seq = (age >= 0);
      chk("lives", 32'(lives), 32'(m_lives));
      chk("freeze", 32'(freeze), 32'(over || seq));
      chk("ghost_reset_n", 32'(ghost_reset_n), 32'(!(age >= DC)));
      chk("player_reset_n", 32'(player_reset_n), 32'(!(age >= DC)));
      chk("death_pulse", 32'(death_pulse), 32'(m_pulse));
      chk("hit_mask", 32'(hit_mask), 32'(m_mask));
      chk("game_over", 32'(game_over), 32'(over));
   endtask

   task automatic step();
      drive();
      @(posedge clk);
      mdl_step();
      #1;
      check_outs();
      st = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic ghosts_far();
      gx[0] = 0;   gy[0] = 0;
      gx[1] = 620; gy[1] = 0;
      gx[2] = 0;   gy[2] = 460;
      gx[3] = 620; gy[3] = 460;
   endtask

   initial begin
      reset = 1'b0;
      st = 0; px = 100; py = 200;
      ghosts_far();
      ppx = 0; ppy = 0;
      for (int g = 0; g < NG; g++) begin pgx[g] = 0; pgy[g] = 0; end
      mdl_reset();
      drive();
      #22;
      check_outs();
      reset = 1'b1;

      // Single catch by ghost 2, then full dying/respawn, with an ignored start in PLAY
      run(3);
      st = 1; run(1);
      gx[2] = 100; gy[2] = 200; run(1);
      ghosts_far(); run(DC + RC + 3);

      // Two ghosts land together: one life lost
      gx[0] = 100; gy[0] = 200; gx[3] = 100; gy[3] = 200; run(1);
      ghosts_far(); run(DC + RC + 3);

      // Pass-through: player (40,60)->(60,60), ghost 1 (60,60)->(40,60)
      px = 40; py = 60; gx[1] = 60; gy[1] = 60; run(2);
      px = 60; py = 60; gx[1] = 40; gy[1] = 60; run(1);
      ghosts_far(); run(DC + RC + 3);

      // Drive to game over and keep overlapping; no further pulses
      gx[0] = px; gy[0] = py; run(3 * (DC + RC + 2));
      st = 1; run(1);
      run(RC + 3);
      ghosts_far(); run(DC + RC + 3);

      // Async reset in the middle of DYING
      gx[2] = px; gy[2] = py; run(4);
      reset = 1'b0;
      #1;
      mdl_reset();
      check_outs();
      #2;
      reset = 1'b1;
      ghosts_far(); run(3);

      // Random play, biased toward catches, swaps and restarts
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            px = 20 * $urandom_range(0, 31); py = 20 * $urandom_range(0, 23);
         end
         for (int g = 0; g < NG; g++) begin
            int r = $urandom_range(0, 39);
            if (r < 8) begin
               gx[g] = 20 * $urandom_range(0, 31); gy[g] = 20 * $urandom_range(0, 23);
            end else if (r < 10) begin
               gx[g] = px; gy[g] = py;
            end else if (r < 12) begin
               int tx = px, ty = py;
               px = gx[g]; py = gy[g]; gx[g] = tx; gy[g] = ty;
            end else if (r < 24) begin
               gx[g] = 20 * $urandom_range(0, 31); gy[g] = 20 * $urandom_range(0, 23);
               if (gx[g] == px && gy[g] == py) gx[g] = (px + 20) % 640;
            end
         end
         st = ($urandom_range(0, 24) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pacman_collision_ctrl.md
# pacman_collision_ctrl

Game-state controller that sits directly downstream of the ghost movement controllers and the player controller. It compares player and ghost tile positions every clock and detects a catch. It then runs the death / respawn / game-over sequence. It drives the active-low resets of the ghost and player controllers and a freeze signal that halts movement while a death is being handled.

## Interface
- `NUM_GHOSTS`, 4, number of ghost position pairs compared
- `X_W`, 10, pixel x width (clog2 of screen width 640)
- `Y_W`, 9, pixel y width (clog2 of screen height 480)
- `INIT_LIVES`, 3, lives loaded at reset and on restart; legal range 1..3
- `DEATH_CYCLES`, 25_000_000, cycles spent in DYING (0.5 s at 50 MHz); must be ≥1
- `RESPAWN_CYCLES`, 2, cycles the movement resets are held low; must be ≥1

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low
- `player_x`  in  X_W  player pixel x, tile-aligned (multiple of 20)
- `player_y`  in  Y_W  player pixel y, tile-aligned
- `ghost_x`  in  NUM_GHOSTS*X_W  ghost i x at bits [i*X_W +: X_W]
- `ghost_y`  in  NUM_GHOSTS*Y_W  ghost i y at bits [i*Y_W +: Y_W]
- `start`  in  1  restart request, single-cycle pulse
- `lives`  out  2  remaining lives
- `freeze`  out  1  high: player and ghost controllers must hold position
- `ghost_reset_n`  out  1  active-low reset to all ghost controllers
- `player_reset_n`  out  1  active-low reset to player controller
- `death_pulse`  out  1  one-cycle strobe per caught event (sound/score)
- `hit_mask`  out  NUM_GHOSTS  ghosts involved in the last catch
- `game_over`  out  1  high in GAME_OVER

## Operation
- States: PLAY, DYING, RESPAWN, GAME_OVER. All outputs are registered.
- Reset values:
  - state=PLAY, lives=INIT_LIVES, counter=0
  - freeze=0, ghost_reset_n=1, player_reset_n=1
  - death_pulse=0, hit_mask=0, game_over=0
  - prev_valid=0
- Direct hit for ghost i: ghost x and y both equal player x and y.
- Swap hit for ghost i (only with `SWAP_DETECT_EN`): prev_valid=1, ghost i current position equals player previous position, and player current position equals ghost i previous position. Catches a pass-through when both move on the same edge.
- Previous-position registers sample all inputs every PLAY cycle. prev_valid is set after the first PLAY cycle. It is cleared on any exit from PLAY.
- PLAY, any hit (OR over all ghosts):
  - next state DYING; lives decrements by 1, saturating at 0
  - death_pulse=1 for one cycle; hit_mask latched with per-ghost hit bits
  - freeze=1; counter loaded with DEATH_CYCLES-1
  - Several simultaneous ghost hits cost exactly one life.
- DYING:
  - counter decrements; collisions and `start` are ignored.
  - At counter==0: go to GAME_OVER if lives==0, else go to RESPAWN with counter=RESPAWN_CYCLES-1.
- RESPAWN:
  - ghost_reset_n=0, player_reset_n=0, freeze=1 for RESPAWN_CYCLES cycles.
  - Then PLAY with both resets=1, freeze=0, hit_mask=0.
- GAME_OVER:
  - freeze=1, game_over=1; lives stays 0 and the state is sticky.
  - `start`=1 → lives=INIT_LIVES, game_over=0, go to RESPAWN with counter=RESPAWN_CYCLES-1.
- `start` outside GAME_OVER is ignored.
- Asynchronous `reset` mid-sequence returns to the reset values immediately, regardless of counter or state.

## Timing
- Hit-to-response latency:
  - hit present on inputs in cycle N (sampled at edge N+1)
  - freeze, death_pulse, hit_mask and the lives decrement are visible after edge N+1
- DYING occupies exactly DEATH_CYCLES cycles.
- RESPAWN resets are low for exactly RESPAWN_CYCLES cycles.
- First PLAY cycle after RESPAWN has prev_valid=0, so a swap hit cannot fire on stale positions. A direct hit can fire immediately.
- Counter width is clog2(max(DEATH_CYCLES,RESPAWN_CYCLES)+1).
- Comparison is exact equality on full X_W/Y_W values; there is no tolerance window.

## Configuration
- `PACMAN_SWAP_DETECT_EN` defined: previous-position registers and swap-hit logic are present.
- Not defined: only direct hits count, the previous-position registers are removed, and prev_valid is tied to 0.

## Test plan
- Parameters: DEATH_CYCLES=8, RESPAWN_CYCLES=2, INIT_LIVES=3.
- Player (100,200), ghost 2 moves to (100,200) → next edge: freeze=1, death_pulse=1 for one cycle, hit_mask=4'b0100, lives=2; 8 cycles later ghost_reset_n and player_reset_n are low for 2 cycles, then PLAY with freeze=0.
- Ghosts 0 and 3 land on the player in the same cycle → single death_pulse, hit_mask=4'b1001, lives decrements by 1 only.
- With the macro: player (40,60)→(60,60) while ghost 1 (60,60)→(40,60) on the same edge → swap hit, lives decrements. Without the macro, the same stimulus → no hit.
- Three catches in a row → after the third DYING, game_over=1, lives=0, freeze=1. Further overlaps produce no death_pulse. A `start` pulse → lives=3, RESPAWN for 2 cycles, then PLAY.
- Assert `reset` low midway through DYING → immediately lives=3, freeze=0, both resets=1, state PLAY. `start` pulsed in PLAY → no effect.
